// File: rtl/pwm_generator.sv
// Single-channel PWM generator with double-buffered period/compare values.
// Period and compare inputs are captured into shadow registers while idle
// and on every period wrap while running. A change made mid-period therefore
// never produces a runt or stretched pulse. The output is registered and
// lags the counter by one cycle.
module pwm_generator #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             pwm_gen_en,
  input  logic [WIDTH-1:0] counter_arr,
  input  logic [WIDTH-1:0] counter_ccr,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Period counter and shadow copies of the period/compare inputs
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] arr_sh_r;
  logic [WIDTH-1:0] ccr_sh_r;
  logic             pwm_r;

  // Decoded conditions based on pre-edge register values
  logic             arr_zero_s;
  logic             wrap_s;
  logic             pwm_next_s;

  // Decode the period wrap and the next output level from the current state
  always_comb begin
    arr_zero_s = 1'b0;
    wrap_s     = 1'b0;
    pwm_next_s = 1'b0;
    if (arr_sh_r == ZERO) begin
      // A zero period holds the counter at 0 and keeps the output low.
      arr_zero_s = 1'b1;
      wrap_s     = 1'b1;
      pwm_next_s = 1'b0;
    end else begin
      // arr_sh_r is non-zero here, so arr_sh_r - 1 cannot underflow.
      arr_zero_s = 1'b0;
      wrap_s     = (cnt_r >= (arr_sh_r - ONE));
      pwm_next_s = (cnt_r < ccr_sh_r);
    end
  end

  // Counter, shadow reload and registered output; reset overrides enable
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      cnt_r    <= ZERO;
      arr_sh_r <= ZERO;
      ccr_sh_r <= ZERO;
      pwm_r    <= 1'b0;
    end else if (!pwm_gen_en) begin
      // Idle: stop immediately and let the shadows follow the inputs so
      // that re-enabling starts a fresh period with the latest values.
      cnt_r    <= ZERO;
      arr_sh_r <= counter_arr;
      ccr_sh_r <= counter_ccr;
      pwm_r    <= 1'b0;
    end else begin
      pwm_r <= pwm_next_s && !arr_zero_s;
      if (wrap_s) begin
        // Period boundary: inputs are sampled only on this edge.
        cnt_r    <= ZERO;
        arr_sh_r <= counter_arr;
        ccr_sh_r <= counter_ccr;
      end else begin
        cnt_r    <= cnt_r + ONE;
        arr_sh_r <= arr_sh_r;
        ccr_sh_r <= ccr_sh_r;
      end
    end
  end

  assign pwm_out = pwm_r;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator. The expected waveform is written
// as runs of high/low cycles derived from the period and compare values;
// each expected bit is queued when the edge that produces it occurs and is
// compared against pwm_out on the following falling edge.
module tb_pwm_generator;

  logic        Clk;
  logic        Rst_n;
  logic        pwm_gen_en;
  logic [31:0] counter_arr;
  logic [31:0] counter_ccr;
  logic        pwm_out;

  typedef struct {
    logic  exp;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  pwm_generator #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .pwm_gen_en  (pwm_gen_en),
    .counter_arr (counter_arr),
    .counter_ccr (counter_ccr),
    .pwm_out     (pwm_out)
  );

  // 50 MHz clock
  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  // Single comparison point for every check in the bench
  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Scoreboard consumer: compare each queued expectation away from the edge
  always @(negedge Clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq(e.tag, {31'd0, pwm_out}, {31'd0, e.exp});
    end
  end

  // One clock edge with the current inputs; queue the level it must produce
  task automatic cycle(input logic e, input string tag);
    exp_t item;
    @(posedge Clk);
    item.exp = e;
    item.tag = tag;
    exp_q.push_back(item);
    #2;
  endtask

  task automatic seg(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) cycle(e, tag);
  endtask

  // Load a corner configuration through idle, then run with a constant level
  task automatic corner(input int arr, input int ccr, input logic e,
                        input string tag);
    pwm_gen_en  = 1'b0;
    counter_arr = 32'(arr);
    counter_ccr = 32'(ccr);
    cycle(1'b0, {tag, "_idle"});
    pwm_gen_en = 1'b1;
    seg(30, e, tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Rst_n       = 1'b1;
    pwm_gen_en  = 1'b0;
    counter_arr = 32'd1000;
    counter_ccr = 32'd400;

    // Reset held, then idle after release
    seg(10, 1'b0, "reset");
    Rst_n = 1'b0;
    seg(5, 1'b0, "idle");

    // 1000/400 for 50 periods, high phase starts on the first enabled edge
    pwm_gen_en = 1'b1;
    for (int p = 0; p < 50; p++) begin
      seg(400, 1'b1, "run400_hi");
      seg(600, 1'b0, "run400_lo");
    end

    // ccr 400 -> 700 mid high phase: current period unaffected
    seg(200, 1'b1, "chg_cur_hi");
    counter_ccr = 32'd700;
    seg(200, 1'b1, "chg_cur_hi");
    seg(600, 1'b0, "chg_cur_lo");
    for (int p = 0; p < 2; p++) begin
      seg(700, 1'b1, "run700_hi");
      seg(300, 0, "run700_lo");
    end

    // Disable mid high phase, reprogram 500/250, re-enable
    seg(300, 1'b1, "pre_stop_hi");
    pwm_gen_en  = 1'b0;
    counter_arr = 32'd500;
    counter_ccr = 32'd250;
    cycle(1'b0, "stop_low");
    seg(3, 1'b0, "stopped");
    pwm_gen_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      seg(250, 1'b1, "run250_hi");
      seg(250, 1'b0, "run250_lo");
    end

    // ccr 250 -> 100 mid period at arr=500: applies from next wrap
    seg(100, 1'b1, "chg2_cur_hi");
    counter_ccr = 32'd100;
    seg(150, 1'b1, "chg2_cur_hi");
    seg(250, 1'b0, "chg2_cur_lo");
    seg(100, 1'b1, "run100_hi");
    seg(400, 1'b0, "run100_lo");
    seg(50, 1'b1, "pre_stop2_hi");
    pwm_gen_en = 1'b0;
    cycle(1'b0, "stop2_low");
    seg(2, 1'b0, "stopped2");

    // Boundary configurations
    corner(10, 0, 1'b0, "ccr0");
    corner(8, 8, 1'b1, "ccr_eq_arr");
    corner(8, 20, 1'b1, "ccr_gt_arr");
    corner(0, 5, 1'b0, "arr0");
    corner(1, 1, 1'b1, "arr1");

    // Reset mid-period while enabled: clears shadows, then restarts cleanly
    pwm_gen_en  = 1'b0;
    counter_arr = 32'd1000;
    counter_ccr = 32'd400;
    cycle(1'b0, "pre_rst_idle");
    pwm_gen_en = 1'b1;
    seg(100, 1'b1, "pre_rst_hi");
    Rst_n = 1'b1;
    cycle(1'b0, "rst_mid");
    cycle(1'b0, "rst_hold");
    Rst_n = 1'b0;
    cycle(1'b0, "post_rst_zero_arr");
    seg(400, 1'b1, "post_rst_hi");
    seg(600, 1'b0, "post_rst_lo");

    // Let the consumer drain the last expectation
    @(negedge Clk);
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
